// File: rtl/mem_bridge_pkg.sv
// Shared types and constants for the memory-stage req/ack bridge.
package mem_bridge_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned LANE_W = 8;
    localparam int unsigned LANES  = DATA_W / LANE_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_e;

    // Operand fields latched at acceptance that the later phases still need.
    typedef struct packed {
        logic              we;
        logic              byte_op;
        logic [1:0]        lane;
        logic [LANE_W-1:0] sb_data;
    } op_t;

endpackage

// File: rtl/mem_bridge_byte_lane.sv
// Byte-lane helper: merges a store byte into a word and extracts/sign-extends a load byte.
module mem_bridge_byte_lane
    import mem_bridge_pkg::*;
(
    input  logic [1:0]        lane_sel,
    input  logic [DATA_W-1:0] word_in,
    input  logic [LANE_W-1:0] byte_in,
    output logic [DATA_W-1:0] merged_c,
    output logic [DATA_W-1:0] lb_ext_c
);

    logic [LANE_W-1:0] lane_byte;

    // Little-endian lanes: lane k occupies bits [8k+7:8k].
    always_comb begin
        merged_c  = word_in;
        lane_byte = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            if (lane_sel == 2'(k)) begin
                merged_c[k*LANE_W +: LANE_W] = byte_in;
                lane_byte                    = word_in[k*LANE_W +: LANE_W];
            end
        end
        lb_ext_c = {{(DATA_W-LANE_W){lane_byte[LANE_W-1]}}, lane_byte};
    end

endmodule

// File: rtl/mem_bridge.sv
// Memory-stage bridge: turns a single-cycle CPU data access into a req/ack
// transaction on a word-wide memory, with read-modify-write for byte stores.
module mem_bridge
    import mem_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic              cpu_byte,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_done,
    output logic              cpu_busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    state_e            state_q, state_d;
    op_t               op_q, op_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic              cpu_done_q, cpu_done_d;
    logic              cpu_busy_q, cpu_busy_d;
    logic [DATA_W-1:0] merged_c, lb_ext_c;

    mem_bridge_byte_lane u_byte_lane (
        .lane_sel (op_q.lane),
        .word_in  (mem_rdata),
        .byte_in  (op_q.sb_data),
        .merged_c (merged_c),
        .lb_ext_c (lb_ext_c)
    );

    // Next-state and registered-output logic; mem_ack only matters in RD/WR,
    // which are exactly the states where mem_req is high.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_rdata_d = cpu_rdata_q;

        unique case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    op_d.we      = cpu_we;
                    op_d.byte_op = cpu_byte;
                    op_d.lane    = cpu_addr[1:0];
                    op_d.sb_data = cpu_wdata[LANE_W-1:0];
                    mem_addr_d   = {cpu_addr[ADDR_W-1:2], 2'b00};
                    mem_req_d    = 1'b1;
                    if (cpu_we && !cpu_byte) begin
                        state_d     = WR;
                        mem_we_d    = 1'b1;
                        mem_wdata_d = cpu_wdata;
                    end else begin
                        state_d  = RD;
                        mem_we_d = 1'b0;
                    end
                end
            end
            RD: begin
                if (mem_ack) begin
                    if (op_q.we) begin
                        state_d     = WR;
                        mem_we_d    = 1'b1;
                        mem_wdata_d = merged_c;
                    end else begin
                        state_d     = DONE;
                        mem_req_d   = 1'b0;
                        cpu_rdata_d = op_q.byte_op ? lb_ext_c : mem_rdata;
                    end
                end
            end
            WR: begin
                if (mem_ack) begin
                    state_d   = DONE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        cpu_done_d = (state_d == DONE);
        cpu_busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            op_q        <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_rdata_q <= '0;
            cpu_done_q  <= 1'b0;
            cpu_busy_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            cpu_done_q  <= cpu_done_d;
            cpu_busy_q  <= cpu_busy_d;
        end
    end

    assign cpu_rdata = cpu_rdata_q;
    assign cpu_done  = cpu_done_q;
    assign cpu_busy  = cpu_busy_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_bridge.sv
// Self-checking bench for mem_bridge: directed vector table, reset/handshake
// corner sequences, and random accesses against a word-array reference model.
module tb_mem_bridge;

    logic        clk;
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    logic        cpu_byte;
    logic [11:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_done;
    logic        cpu_busy;
    logic        mem_req;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    mem_bridge #(.ADDR_W(12)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_byte  (cpu_byte),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_done  (cpu_done),
        .cpu_busy  (cpu_busy),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave memory, responder and transaction log
    typedef struct {
        logic        we;
        logic [11:0] addr;
        logic [31:0] wdata;
    } phase_t;

    logic [31:0] bmem    [1024];
    logic [31:0] ref_mem [1024];
    phase_t      ph_buf  [64];
    int          ph_total = 0;
    int          cnt = 0;
    int          wait_n;
    bit          resp_en;
    logic        resp_ack = 1'b0;
    logic [31:0] resp_rdata = 32'h0;
    logic        man_ack;
    bit          pre_en;
    logic [9:0]  pre_idx;
    logic [31:0] pre_val;

    assign mem_ack   = resp_en ? resp_ack : man_ack;
    assign mem_rdata = resp_rdata;

    always @(negedge clk) begin
        if (resp_en && mem_req) begin
            if (cnt >= wait_n) begin
                resp_ack   = 1'b1;
                resp_rdata = bmem[mem_addr[11:2]];
                cnt        = 0;
            end else begin
                resp_ack   = 1'b0;
                resp_rdata = $urandom;
                cnt++;
            end
        end else begin
            resp_ack = 1'b0;
            cnt      = 0;
        end
    end

    always @(posedge clk) begin
        if (pre_en) begin
            bmem[pre_idx] = pre_val;
        end else if (rst && mem_req && mem_ack) begin
            ph_buf[ph_total & 63] = '{mem_we, mem_addr, mem_wdata};
            ph_total++;
            if (mem_we) bmem[mem_addr[11:2]] = mem_wdata;
        end
    end

    int          nchecks = 0;
    int          nerrors = 0;
    logic [31:0] last_rd;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic preload(input logic [9:0] idx, input logic [31:0] val);
        pre_idx = idx;
        pre_val = val;
        pre_en  = 1'b1;
        step();
        pre_en       = 1'b0;
        ref_mem[idx] = val;
    endtask

    // One CPU access from acceptance to the idle cycle after cpu_done.
    task automatic do_access(input logic we, input logic bt, input logic [11:0] addr,
                             input logic [31:0] wd, input int waits, input int exp_cyc,
                             input int exp_ph, input logic [31:0] exp_rd,
                             input logic [31:0] exp_word, input string nm);
        int          n;
        int          ph0;
        int          ph_seen;
        bit          seen;
        bit          have;
        logic [44:0] snap;
        logic [11:0] aligned;
        aligned = {addr[11:2], 2'b00};
        wait_n  = waits;
        ph0     = ph_total;
        ph_seen = ph_total;
        have    = 1'b0;
        seen    = 1'b0;
        n       = 0;
        snap    = '0;
        cpu_we  = we;
        cpu_byte = bt;
        cpu_addr = addr;
        cpu_wdata = wd;
        cpu_req = 1'b1;
        while (!seen && n < 200) begin
            step();
            n++;
            if (n == 1) begin
                cpu_addr  = addr ^ 12'hFF3;
                cpu_wdata = ~wd;
            end
            if (mem_req) begin
                if (have && ph_seen == ph_total)
                    chk({nm, ":mem_hold"}, 32'({mem_we, mem_addr, mem_wdata} !== snap), 32'd0);
                else begin
                    snap    = {mem_we, mem_addr, mem_wdata};
                    have    = 1'b1;
                    ph_seen = ph_total;
                end
            end else begin
                have = 1'b0;
            end
            if (cpu_done) seen = 1'b1;
            else chk({nm, ":busy"}, 32'(cpu_busy), 32'd1);
        end
        cpu_req = 1'b0;
        chk({nm, ":done_seen"}, 32'(seen), 32'd1);
        chk({nm, ":latency"}, 32'(n), 32'(exp_cyc));
        chk({nm, ":rdata"}, cpu_rdata, exp_rd);
        chk({nm, ":busy_in_done"}, 32'(cpu_busy), 32'd1);
        chk({nm, ":phases"}, 32'(ph_total - ph0), 32'(exp_ph));
        for (int j = 0; j < exp_ph && j < ph_total - ph0; j++) begin
            phase_t p;
            p = ph_buf[(ph0 + j) & 63];
            chk({nm, ":ph_addr"}, 32'(p.addr), 32'(aligned));
            chk({nm, ":ph_we"}, 32'(p.we), (exp_ph == 2) ? 32'(j == 1) : 32'(we));
            if (p.we) chk({nm, ":ph_wdata"}, p.wdata, exp_word);
        end
        step();
        chk({nm, ":done_pulse"}, 32'(cpu_done), 32'd0);
        chk({nm, ":idle_busy"}, 32'(cpu_busy), 32'd0);
        chk({nm, ":idle_req"}, 32'(mem_req), 32'd0);
        chk({nm, ":mem_word"}, bmem[aligned[11:2]], exp_word);
        chk({nm, ":rdata_hold"}, cpu_rdata, exp_rd);
    endtask

    typedef struct {
        logic        we;
        logic        bt;
        logic [11:0] addr;
        logic [31:0] wdata;
        int          waits;
        bit          pre;
        logic [11:0] pre_addr;
        logic [31:0] pre_val;
        int          exp_cyc;
        int          exp_ph;
        logic [31:0] exp_rd;
        logic [31:0] exp_word;
    } vec_t;

    vec_t vecs [5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        bit          seen;
        logic        r_we;
        logic        r_bt;
        logic [11:0] r_a;
        logic [31:0] r_d;
        logic [31:0] r_word;
        logic [31:0] r_rd;
        int          r_w;
        int          r_idx;
        int          r_k;

        vecs[0] = '{1'b1, 1'b0, 12'h010, 32'hDEADBEEF, 0, 1'b0, 12'h000, 32'h0,
                    2, 1, 32'h0, 32'hDEADBEEF};
        vecs[1] = '{1'b1, 1'b1, 12'h013, 32'hA5A5A55A, 3, 1'b1, 12'h010, 32'h11223344,
                    9, 2, 32'h0, 32'h5A223344};
        vecs[2] = '{1'b0, 1'b1, 12'h012, 32'h0, 0, 1'b1, 12'h010, 32'h00F10000,
                    2, 1, 32'hFFFFFFF1, 32'h00F10000};
        vecs[3] = '{1'b0, 1'b1, 12'h011, 32'h0, 0, 1'b1, 12'h010, 32'h00007F00,
                    2, 1, 32'h0000007F, 32'h00007F00};
        vecs[4] = '{1'b0, 1'b0, 12'h027, 32'h0, 0, 1'b1, 12'h024, 32'hCAFEF00D,
                    2, 1, 32'hCAFEF00D, 32'hCAFEF00D};

        rst = 1'b0; cpu_req = 1'b1; cpu_we = 1'b1; cpu_byte = 1'b0;
        cpu_addr = 12'h010; cpu_wdata = 32'h12345678;
        resp_en = 1'b1; man_ack = 1'b0; pre_en = 1'b0; pre_idx = '0; pre_val = '0;
        wait_n = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset:rdata", cpu_rdata, 32'h0);
        chk("reset:done", 32'(cpu_done), 32'd0);
        chk("reset:busy", 32'(cpu_busy), 32'd0);
        chk("reset:mem_req", 32'(mem_req), 32'd0);
        chk("reset:mem_we", 32'(mem_we), 32'd0);
        chk("reset:mem_addr", 32'(mem_addr), 32'd0);
        chk("reset:mem_wdata", mem_wdata, 32'h0);
        cpu_req = 1'b0;
        rst = 1'b1;
        step();

        for (int i = 0; i < 5; i++) begin
            if (vecs[i].pre) preload(vecs[i].pre_addr[11:2], vecs[i].pre_val);
            do_access(vecs[i].we, vecs[i].bt, vecs[i].addr, vecs[i].wdata, vecs[i].waits,
                      vecs[i].exp_cyc, vecs[i].exp_ph, vecs[i].exp_rd, vecs[i].exp_word,
                      $sformatf("vec%0d", i));
        end

        // Reset in the middle of a write whose ack never comes, then a late ack.
        preload(10'h00C, 32'h0BADF00D);
        resp_en = 1'b0; man_ack = 1'b0;
        cpu_we = 1'b1; cpu_byte = 1'b0; cpu_addr = 12'h030; cpu_wdata = 32'h13572468;
        cpu_req = 1'b1;
        step();
        chk("rstmid:wr_req", 32'(mem_req), 32'd1);
        chk("rstmid:wr_we", 32'(mem_we), 32'd1);
        step();
        chk("rstmid:wr_busy", 32'(cpu_busy), 32'd1);
        rst = 1'b0; cpu_req = 1'b0;
        step();
        chk("rstmid:mem_req", 32'(mem_req), 32'd0);
        chk("rstmid:mem_we", 32'(mem_we), 32'd0);
        chk("rstmid:busy", 32'(cpu_busy), 32'd0);
        chk("rstmid:done", 32'(cpu_done), 32'd0);
        chk("rstmid:rdata", cpu_rdata, 32'h0);
        chk("rstmid:mem_addr", 32'(mem_addr), 32'd0);
        chk("rstmid:mem_wdata", mem_wdata, 32'h0);
        rst = 1'b1; man_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("lateack:done", 32'(cpu_done), 32'd0);
            chk("lateack:busy", 32'(cpu_busy), 32'd0);
            chk("lateack:mem_req", 32'(mem_req), 32'd0);
        end
        man_ack = 1'b0; resp_en = 1'b1;
        chk("lateack:mem_word", bmem[12], 32'h0BADF00D);

        // Spurious ack while idle.
        resp_en = 1'b0; man_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("spur:busy", 32'(cpu_busy), 32'd0);
            chk("spur:mem_req", 32'(mem_req), 32'd0);
            chk("spur:done", 32'(cpu_done), 32'd0);
        end
        man_ack = 1'b0; resp_en = 1'b1;

        // Request held through DONE is taken as a fresh access one cycle later.
        preload(10'h010, 32'h12345678);
        preload(10'h011, 32'h9ABCDEF0);
        wait_n = 0;
        cpu_we = 1'b0; cpu_byte = 1'b0; cpu_addr = 12'h040; cpu_req = 1'b1;
        n = 0; seen = 1'b0;
        while (!seen && n < 50) begin
            step(); n++; seen = cpu_done;
        end
        chk("held:first_done", 32'(seen), 32'd1);
        chk("held:first_rdata", cpu_rdata, 32'h12345678);
        cpu_addr = 12'h044;
        step();
        chk("held:gap_busy", 32'(cpu_busy), 32'd0);
        chk("held:gap_req", 32'(mem_req), 32'd0);
        chk("held:gap_done", 32'(cpu_done), 32'd0);
        step();
        chk("held:second_req", 32'(mem_req), 32'd1);
        chk("held:second_addr", 32'(mem_addr), 32'h044);
        chk("held:second_busy", 32'(cpu_busy), 32'd1);
        n = 0; seen = 1'b0;
        while (!seen && n < 50) begin
            step(); n++; seen = cpu_done;
        end
        cpu_req = 1'b0;
        chk("held:second_done", 32'(seen), 32'd1);
        chk("held:second_rdata", cpu_rdata, 32'h9ABCDEF0);
        step();
        chk("held:idle", 32'(cpu_busy), 32'd0);
        last_rd = 32'h9ABCDEF0;

        // Random accesses checked against the word-array reference model.
        for (int i = 0; i < 16; i++) preload(10'(i), $urandom);
        for (int i = 0; i < 40; i++) begin
            r_we  = 1'($urandom);
            r_bt  = 1'($urandom);
            r_a   = 12'($urandom_range(0, 63));
            r_d   = $urandom;
            r_w   = int'($urandom_range(0, 2));
            r_idx = int'(r_a[11:2]);
            r_k   = int'(r_a[1:0]);
            if (!r_we) begin
                r_word = ref_mem[r_idx];
                r_rd   = r_bt ? 32'($signed(8'(r_word >> (8 * r_k)))) : r_word;
                last_rd = r_rd;
                do_access(r_we, r_bt, r_a, r_d, r_w, 2 + r_w, 1, r_rd, r_word,
                          $sformatf("rand%0d", i));
            end else if (!r_bt) begin
                ref_mem[r_idx] = r_d;
                do_access(r_we, r_bt, r_a, r_d, r_w, 2 + r_w, 1, last_rd, r_d,
                          $sformatf("rand%0d", i));
            end else begin
                r_word = (ref_mem[r_idx] & ~(32'hFF << (8 * r_k)))
                       | ((r_d & 32'hFF) << (8 * r_k));
                ref_mem[r_idx] = r_word;
                do_access(r_we, r_bt, r_a, r_d, r_w, 3 + 2 * r_w, 2, last_rd, r_word,
                          $sformatf("rand%0d", i));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule

// File: doc/mem_bridge.md
Name: mem_bridge

Overview:
- Sits directly downstream of the multi-cycle datapath's memory stage, in place of the zero-wait data memory.
- Takes the registered ALU address, store data, write strobe and byte flag, and runs a req/ack handshake to a slower word-wide data memory.
- Performs read-modify-write for byte stores and sign-extension for byte loads.
- Drives a busy/done pair so the controller holds its MEM state until the access completes.

Parameters:
- ADDR_W, 12: byte-address width; memory is word-addressed internally.
- DATA_W, 32: data width; fixed at 32, byte-lane logic assumes 4 lanes.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-low
- cpu_req  in  1  access request; held by controller until cpu_done
- cpu_we  in  1  1 = store, 0 = load
- cpu_byte  in  1  1 = byte access (lb/sb), 0 = word
- cpu_addr  in  ADDR_W  byte address
- cpu_wdata  in  32  store data; byte stores use [7:0]
- cpu_rdata  out  32  load result; byte loads sign-extended
- cpu_done  out  1  one-cycle completion pulse
- cpu_busy  out  1  high whenever state != IDLE
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  word-aligned address {cpu_addr[ADDR_W-1:2], 2'b00}
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data; valid when mem_ack is high
- mem_ack  in  1  memory completion, sampled on clk

Behaviour:
- Reset (rst==0 at an edge), including mid-operation:
  - state = IDLE; all outputs 0; latched operands cleared.
  - No pending ack is honoured after reset.
- States: IDLE, RD, WR, DONE.
- IDLE:
  - cpu_req sampled only here.
  - On cpu_req=1, latch addr, we, byte and wdata.
  - Next state:
    - load (word or byte) -> RD
    - word store -> WR
    - byte store -> RD, for read-modify-write
- RD:
  - mem_req=1, mem_we=0, mem_addr held.
  - On mem_ack=1:
    - For a load: capture the result into cpu_rdata -> DONE.
    - For a byte store: merge the latched byte into the lane addr[1:0] of mem_rdata, store it as mem_wdata -> WR.
- WR:
  - mem_req=1, mem_we=1, mem_addr and mem_wdata held stable.
  - On mem_ack=1 -> DONE.
- DONE:
  - cpu_done=1 for exactly one cycle -> IDLE.
  - cpu_rdata stays valid and holds until the next load completes.
- Handshake rules:
  - mem_req, mem_we, mem_addr and mem_wdata are registered.
  - They are stable from request assertion until the ack edge.
  - mem_req deasserts at the edge following the ack edge.
  - mem_ack is ignored when mem_req=0.
  - Any number of wait cycles is allowed; there is no timeout.
- Byte lanes are little-endian: lane k = bits [8k+7:8k], k = addr[1:0].
  - lb: cpu_rdata = {{24{b[7]}}, b}, where b is the selected lane.
  - sb: the other three lanes are preserved from the read.
- Word access with addr[1:0] != 0: the low bits are ignored and the access goes to the aligned word.
- Latency, with ack arriving in the first request cycle:
  - Word load or word store: done 2 cycles after acceptance.
  - Byte store: done 3 cycles after acceptance.
  - Each wait cycle adds 1.
- cpu_req is not sampled in DONE. A request held into the cycle after DONE is treated as a new access, so the controller must drop cpu_req on cpu_done.
- cpu_wdata and cpu_addr changes after acceptance have no effect.

Decomposition:
- Shared package:
  - state encoding: IDLE=2'd0, RD=2'd1, WR=2'd2, DONE=2'd3
  - lane width constant 8
- One natural sub-module, byte_lane: combinational lane merge for stores and extract/sign-extend for loads, selected by addr[1:0].

Test Plan:
1. Word store addr=0x010, data=0xDEADBEEF, ack on 1st req cycle -> one WR with mem_addr=0x010 and mem_wdata=0xDEADBEEF; cpu_done 2 cycles after acceptance; memory model holds 0xDEADBEEF.
2. Byte store 0x5A to addr=0x013, memory word=0x11223344, ack delayed 3 cycles per phase -> RD then WR with mem_wdata=0x5A223344; cpu_busy high throughout; single cpu_done pulse.
3. Byte load addr=0x012 from word 0x00F10000 -> cpu_rdata=0xFFFFFFF1. Byte load addr=0x011 from word 0x00007F00 -> cpu_rdata=0x0000007F.
4. Word load addr=0x027 (misaligned) from word at 0x024 = 0xCAFEF00D -> mem_addr=0x024, cpu_rdata=0xCAFEF00D.
5. Reset mid-operation: rst=0 during WR with mem_ack stuck low -> next edge: mem_req=0, cpu_busy=0, state IDLE. A late mem_ack after reset is ignored and causes no cpu_done.
6. Spurious mem_ack=1 in IDLE, plus cpu_req held 1 through DONE -> no state change from the ack. A second access begins exactly one cycle after cpu_done.
